data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Memory-side responder for the CPU's mem_req/mem_ready data interface.
//   Holds a DEPTH x DATA_W storage array and serves one load or store per request,
//   inserting WAIT_CYCLES wait states. mem_ready is a one-cycle pulse.
//   Sits beside simple_cpu in the top level; also serves as the bench memory model.
// PARAMETERS
//   ADDR_W       8    address width; DEPTH = 2**ADDR_W
//   DATA_W       8    data width
//   WAIT_CYCLES  2    wait states from request accept to mem_ready (0..15)
//   WP_BASE      8'hF0  lowest write-protected address (used only with MEM_WP_EN)
// PORTS
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   mem_req    in   1       request, held by initiator until mem_ready sampled
//   mem_we     in   1       1 = store, 0 = load; valid with mem_req
//   mem_addr   in   ADDR_W  access address; valid with mem_req
//   mem_wdata  in   DATA_W  store data; valid with mem_req
//   mem_rdata  out  DATA_W  load data (store: echo of written data); valid while mem_ready=1
//   mem_ready  out  1       one-cycle completion pulse
//   mem_err    out  1       protection error, pulses with mem_ready (0 without MEM_WP_EN)
//   init_we    in   1       backdoor preload write strobe (bench/boot use)
//   init_addr  in   ADDR_W  backdoor address
//   init_data  in   DATA_W  backdoor data
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, mem_ready=0, mem_rdata=0, mem_err=0,
//     wait counter=0, every storage word=0. Any in-flight access is discarded; a
//     pending store is not performed.
//   - FSM:
//     - IDLE: when mem_req=1, latch mem_we/mem_addr/mem_wdata and load counter=WAIT_CYCLES.
//       Go to RESP if WAIT_CYCLES==0, else WAIT.
//     - WAIT: decrement counter each cycle; when counter==1, go to RESP.
//     - RESP: mem_ready=1 for exactly this cycle. Store: array[addr] written on
//       entry to RESP, mem_rdata=wdata. Load: mem_rdata=array[addr] read on entry. Go to RECOVER.
//     - RECOVER: mem_ready=0; stay until mem_req=0, then IDLE. Prevents re-accepting
//       a request still high in the cycle after mem_ready.
//   - Latency: mem_ready asserts WAIT_CYCLES+1 cycles after the edge mem_req is first
//     sampled high. Minimum back-to-back spacing: WAIT_CYCLES+3 cycles.
//   - mem_rdata holds its last value outside RESP; only meaningful while mem_ready=1.
//   - Input changes while in WAIT/RESP/RECOVER are ignored; the latched copy is used.
//   - Address wraps naturally at ADDR_W bits; no out-of-range condition exists.
//   - Backdoor: init_we writes init_data to init_addr in any state at the clock edge.
//     If it hits the same address as an FSM store in the same cycle, the FSM store wins.
//     A load that coincides with a backdoor write to its address returns the old value.
// CONFIGURATION
//   - MEM_WP_EN defined: stores with latched addr >= WP_BASE are dropped (array unchanged).
//     For these stores mem_err=1 in the RESP cycle, mem_ready still pulses, and
//     mem_rdata=current array value. Loads and the backdoor are never protected.
//   - MEM_WP_EN undefined: WP_BASE is unused, mem_err is tied 0, all stores commit.
// STRUCTURE
//   - data_mem_pkg: state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2, RECOVER=2'd3),
//     WAIT_W=4 counter width constant.
//   - Sub-module data_mem_array: storage with one sync FSM write port, one backdoor
//     write port (with priority), one read port, and reset clear.
//     FSM, counter and protection check stay in data_mem_responder.
// TESTING
//   1. Load, WAIT_CYCLES=2: init 0x10<=0x5A; req load 0x10 -> mem_ready high exactly
//      3 cycles after req sampled, mem_rdata=0x5A, single-cycle pulse.
//   2. Store then load: store 0x22<=0xC3, then load 0x22 -> store returns rdata=0xC3;
//      load returns 0xC3.
//   3. Held request: keep mem_req=1 for 2 cycles after the ready pulse -> no second
//      mem_ready until req drops and is reasserted.
//   4. WAIT_CYCLES=0: load 0x00 after reset -> ready on the next cycle, rdata=0x00.
//   5. Reset mid-op: rst_n low during WAIT of store 0x30<=0xFF -> mem_ready=0
//      immediately; after release, load 0x30 returns 0x00.
//   6. MEM_WP_EN: store 0xF4<=0x11 -> mem_ready=1, mem_err=1, and a later load of
//      0xF4 returns 0x00; store 0xEF<=0x11 -> mem_err=0 and it commits.

Source files
------------

// File: rtl/data_mem_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_pkg
//   Shared definitions for the data memory responder: FSM state encoding and
//   the width of the wait-state counter.
// ---------------------------------------------------------------------------
package data_mem_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESP    = 2'd2,
        ST_RECOVER = 2'd3
    } mem_state_t;

endpackage

// File: rtl/data_mem_array.sv
// ---------------------------------------------------------------------------
// data_mem_array
//   DEPTH x DATA_W storage with asynchronous clear, one synchronous write
//   port driven by the responder FSM, one synchronous backdoor write port and
//   one combinational read port.
// Ports
//   clk, rst_n              clock (rising edge), async active-low clear
//   we, waddr, wdata        FSM write port (wins over the backdoor)
//   init_we, init_addr,
//   init_data               backdoor preload write port
//   raddr, rdata            combinational read port (returns pre-edge value)
// ---------------------------------------------------------------------------
module data_mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // The FSM write is issued last so it overrides a backdoor write to the
    // same address in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (init_we) begin
                mem[init_addr] <= init_data;
            end
            if (we) begin
                mem[waddr] <= wdata;
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the CPU mem_req/mem_ready data interface.
//   Serves one load or store per request after WAIT_CYCLES wait states and
//   signals completion with a one-cycle mem_ready pulse.
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   mem_req             request, held by initiator until mem_ready seen
//   mem_we              1 = store, 0 = load
//   mem_addr, mem_wdata access address and store data
//   mem_rdata           load data / store echo, valid while mem_ready=1
//   mem_ready           one-cycle completion pulse
//   mem_err             write-protection error, pulses with mem_ready
//   init_we/addr/data   backdoor preload write port
// Configuration
//   MEM_WP_EN  when defined, stores to addresses >= WP_BASE are dropped and
//              flagged with mem_err; otherwise mem_err is tied low.
// ---------------------------------------------------------------------------
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int WP_BASE     = 'hF0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_err,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

    mem_state_t        state, next_state;
    logic [WAIT_W-1:0] cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              enter_resp;
    logic              prot;
    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;

    // With WAIT_CYCLES=0 the access completes on the accepting edge, before
    // the latches hold the request, so the live inputs are used in IDLE.
    assign acc_we     = (state == ST_IDLE) ? mem_we    : lat_we;
    assign acc_addr   = (state == ST_IDLE) ? mem_addr  : lat_addr;
    assign acc_wdata  = (state == ST_IDLE) ? mem_wdata : lat_wdata;
    assign enter_resp = (state != ST_RESP) && (next_state == ST_RESP);

`ifdef MEM_WP_EN
    assign prot = acc_we && (acc_addr >= ADDR_W'(WP_BASE));
`else
    logic unused_wp;
    assign unused_wp = (acc_addr >= ADDR_W'(WP_BASE));
    assign prot      = 1'b0;
`endif

    assign arr_we = enter_resp && acc_we && !prot;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (mem_req) begin
                    next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == WAIT_W'(1)) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                next_state = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (!mem_req) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        mem_ready = (state == ST_RESP);
        mem_err   = (state == ST_RESP) && err_q;
        mem_rdata = rdata_q;
    end

    // Wait counter, response data and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && mem_req) begin
                cnt <= WAIT_INIT;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - WAIT_W'(1);
            end
            if (enter_resp) begin
                // A dropped store returns the unchanged array contents.
                rdata_q <= (acc_we && !prot) ? acc_wdata : arr_rdata;
                err_q   <= prot;
            end
        end
    end

    // Request latches
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && mem_req) begin
            lat_we    <= mem_we;
            lat_addr  <= mem_addr;
            lat_wdata <= mem_wdata;
        end
    end

    data_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (arr_we),
        .waddr     (acc_addr),
        .wdata     (acc_wdata),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .raddr     (acc_addr),
        .rdata     (arr_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed bench: dut0 uses WAIT_CYCLES=2, dut1 uses WAIT_CYCLES=0. Both
//   share the access and backdoor buses; each has its own mem_req.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic       mem_we = 1'b0;
    logic [7:0] mem_addr = '0;
    logic [7:0] mem_wdata = '0;
    logic       init_we = 1'b0;
    logic [7:0] init_addr = '0;
    logic [7:0] init_data = '0;
    logic [7:0] rdata0, rdata1;
    logic       rdy0, rdy1, err0, err1;

    int checks = 0;
    int errors = 0;

`ifdef MEM_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(2), .WP_BASE('hF0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_req(req0), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata0),
        .mem_ready(rdy0), .mem_err(err0), .init_we(init_we),
        .init_addr(init_addr), .init_data(init_data)
    );

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0), .WP_BASE('hF0)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_req(req1), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata1),
        .mem_ready(rdy1), .mem_err(err1), .init_we(init_we),
        .init_addr(init_addr), .init_data(init_data)
    );

    typedef struct {
        string      name;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic backdoor(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        init_we = 1'b1; init_addr = a; init_data = d;
        @(posedge clk); #1;
        init_we = 1'b0;
    endtask

    // One complete handshake; lat counts edges from the sampling edge to ready.
    task automatic access(input bit sel, input logic we, input logic [7:0] a,
                          input logic [7:0] wd, output logic [7:0] rd,
                          output logic er, output int lat);
        @(negedge clk);
        mem_we = we; mem_addr = a; mem_wdata = wd;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        lat = 0; rd = '0; er = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (sel ? rdy1 : rdy0) begin
                lat = i;
                rd  = sel ? rdata1 : rdata0;
                er  = sel ? err1 : err0;
                break;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got no mem_ready, expected one within 20 cycles");
        end
        @(posedge clk); #1;
        check("ready_single_pulse", 32'(sel ? rdy1 : rdy0), 32'd0);
        @(posedge clk); #1;
    endtask

    vec_t       vecs[9];
    logic [7:0] rd;
    logic       er;
    int         lat;
    bit         seen;

    initial begin
        vecs[0] = '{"load_preloaded",   1'b0, 8'h10, 8'h00, 8'h5A, 1'b0};
        vecs[1] = '{"store_echo",       1'b1, 8'h22, 8'hC3, 8'hC3, 1'b0};
        vecs[2] = '{"load_after_store", 1'b0, 8'h22, 8'h00, 8'hC3, 1'b0};
        vecs[3] = '{"load_unwritten",   1'b0, 8'h55, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{"store_80",         1'b1, 8'h80, 8'h01, 8'h01, 1'b0};
        vecs[5] = '{"store_wp_f4",      1'b1, 8'hF4, 8'h11, WP ? 8'h00 : 8'h11, WP};
        vecs[6] = '{"load_f4",          1'b0, 8'hF4, 8'h00, WP ? 8'h00 : 8'h11, 1'b0};
        vecs[7] = '{"store_ef",         1'b1, 8'hEF, 8'h11, 8'h11, 1'b0};
        vecs[8] = '{"load_ef",          1'b0, 8'hEF, 8'h00, 8'h11, 1'b0};

        // Reset state
        #12;
        check("reset_ready", 32'(rdy0), 32'd0);
        check("reset_rdata", 32'(rdata0), 32'd0);
        check("reset_err",   32'(err0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        backdoor(8'h10, 8'h5A);

        // Table-driven accesses on the WAIT_CYCLES=2 responder
        for (int v = 0; v < 9; v++) begin
            access(1'b0, vecs[v].we, vecs[v].addr, vecs[v].wdata, rd, er, lat);
            check({vecs[v].name, "_rdata"}, 32'(rd), 32'(vecs[v].exp_rdata));
            check({vecs[v].name, "_err"}, 32'(er), 32'(vecs[v].exp_err));
            check({vecs[v].name, "_latency"}, 32'(lat), 32'd3);
        end

        // Held request: no second ready until req drops and returns
        @(negedge clk);
        mem_we = 1'b0; mem_addr = 8'h10; req0 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            seen = rdy0;
        end
        check("held_first_ready", 32'(seen), 32'd1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("held_no_second_ready", 32'(rdy0), 32'd0);
        end
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk); #1;
        check("held_dropped_no_ready", 32'(rdy0), 32'd0);
        @(posedge clk); #1;
        access(1'b0, 1'b0, 8'h10, 8'h00, rd, er, lat);
        check("held_reassert_rdata", 32'(rd), 32'h5A);
        check("held_reassert_latency", 32'(lat), 32'd3);

        // WAIT_CYCLES=0 responder
        access(1'b1, 1'b0, 8'h00, 8'h00, rd, er, lat);
        check("w0_load_rdata", 32'(rd), 32'h00);
        check("w0_load_latency", 32'(lat), 32'd1);

        // FSM store and backdoor hit the same address on the same edge
        @(negedge clk);
        mem_we = 1'b1; mem_addr = 8'h41; mem_wdata = 8'h22; req1 = 1'b1;
        init_we = 1'b1; init_addr = 8'h41; init_data = 8'h99;
        @(posedge clk); #1;
        init_we = 1'b0;
        check("collide_store_ready", 32'(rdy1), 32'd1);
        check("collide_store_rdata", 32'(rdata1), 32'h22);
        req1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 8'h41, 8'h00, rd, er, lat);
        check("collide_store_wins", 32'(rd), 32'h22);

        // Load coinciding with a backdoor write returns the old value
        backdoor(8'h42, 8'h33);
        @(negedge clk);
        mem_we = 1'b0; mem_addr = 8'h42; req1 = 1'b1;
        init_we = 1'b1; init_addr = 8'h42; init_data = 8'h44;
        @(posedge clk); #1;
        init_we = 1'b0;
        check("collide_load_old", 32'(rdata1), 32'h33);
        req1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 8'h42, 8'h00, rd, er, lat);
        check("collide_load_new", 32'(rd), 32'h44);

        // Reset during WAIT of a store
        @(negedge clk);
        mem_we = 1'b1; mem_addr = 8'h30; mem_wdata = 8'hFF; req0 = 1'b1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("midreset_ready", 32'(rdy0), 32'd0);
        check("midreset_rdata", 32'(rdata0), 32'd0);
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 1'b0, 8'h30, 8'h00, rd, er, lat);
        check("midreset_store_dropped", 32'(rd), 32'h00);
        check("midreset_latency", 32'(lat), 32'd3);
        access(1'b0, 1'b0, 8'h10, 8'h00, rd, er, lat);
        check("midreset_array_cleared", 32'(rd), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
